// File: rtl/outport_alloc_pkg.sv
// -----------------------------------------------------------------------------
// outport_alloc_pkg
// Shared NoC definitions for the output-port allocator:
//   - NPORT_DEF       : default number of arbitrated input ports
//   - PORT_*          : input port index constants (inject, W, S, E, N)
//   - state_e         : allocator lock state encoding
// -----------------------------------------------------------------------------
package outport_alloc_pkg;

   localparam int NPORT_DEF   = 5;

   localparam int PORT_INJECT = 0;
   localparam int PORT_W      = 1;
   localparam int PORT_S      = 2;
   localparam int PORT_E      = 3;
   localparam int PORT_N      = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,   // no packet owns the output
      ST_LOCKED = 1'b1    // owner holds the output until its tail flit
   } state_e;

endpackage

// File: rtl/outport_alloc_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin picker: scans mask starting at ptr, wrapping N-1 -> 0, and
// reports the first set bit.
//   mask    : candidate requests
//   ptr     : index where the search starts (always < N)
//   win     : one-hot winner (zero when mask is empty)
//   win_idx : binary index of the winner
//   any     : mask has at least one bit set
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 5,
   parameter int PW = 3
) (
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [PW-1:0] win_idx,
   output logic          any
);

   logic found;
   int   j;

   // NOTE: every signal written here gets a default before the loop so no
   // path leaves it unassigned; that is what keeps this logic latch-free.
   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && mask[j]) begin
            found      = 1'b1;
            win[j]     = 1'b1;
            win_idx    = PW'(j);
         end
      end
   end

   assign any = |mask;

endmodule

// File: rtl/outport_alloc.sv
// -----------------------------------------------------------------------------
// outport_alloc
// Output-port allocator for one router output. Grants one flit per cycle to
// an eligible input, locks the output to that input for the rest of a
// multi-flit packet, and gives multicast packets priority when unlocked.
//   clk       : clock, all state on rising edge
//   rst_      : synchronous active-high reset
//   port      : packed routed destination per input (field i = [i*PORTW +: PORTW])
//   req       : flit valid per input
//   tail      : current flit of input i ends its packet
//   mcast     : current packet of input i is multicast
//   credit_ok : downstream can take one flit this cycle
//   grt       : one-hot grant, combinational
//   sel       : grt delayed by one cycle (output mux select)
//   busy      : output locked to a packet
//   flit_cnt  : wrapping count of granted flits
// -----------------------------------------------------------------------------
module outport_alloc
   import outport_alloc_pkg::*;
#(
   parameter int NPORT  = NPORT_DEF,
   parameter int PORTW  = 3,
   parameter int PORTID = 0,
   parameter int CNTW   = 16
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [NPORT*PORTW-1:0] port,
   input  logic [NPORT-1:0]       req,
   input  logic [NPORT-1:0]       tail,
   input  logic [NPORT-1:0]       mcast,
   input  logic                   credit_ok,
   output logic [NPORT-1:0]       grt,
   output logic [NPORT-1:0]       sel,
   output logic                   busy,
   output logic [CNTW-1:0]        flit_cnt
);

   localparam int PTRW = (NPORT > 1) ? $clog2(NPORT) : 1;

   state_e            state_q, state_d;
   logic [PTRW-1:0]   owner_q, owner_d;
   logic [PTRW-1:0]   ptr_q,   ptr_d;
   logic [NPORT-1:0]  sel_q,   sel_d;
   logic [CNTW-1:0]   cnt_q,   cnt_d;

   logic [NPORT-1:0]  elig;
   logic [NPORT-1:0]  mc_elig;
   logic [NPORT-1:0]  pick_mask;
   logic [NPORT-1:0]  pick_win;
   logic [PTRW-1:0]   pick_idx;
   logic              pick_any;
   logic [NPORT-1:0]  owner_oh;

   function automatic logic [PTRW-1:0] inc_wrap(input logic [PTRW-1:0] v);
      if (int'(v) >= NPORT - 1) return '0;
      return v + 1'b1;
   endfunction

   always_comb begin
      elig = '0;
      for (int i = 0; i < NPORT; i++) begin
         elig[i] = req[i] && (port[i*PORTW +: PORTW] == PORTW'(PORTID));
      end
   end

   // Multicast requests shadow unicast ones when the output is free.
   assign mc_elig   = elig & mcast;
   assign pick_mask = (|mc_elig) ? mc_elig : elig;
   assign owner_oh  = {{(NPORT-1){1'b0}}, 1'b1} << owner_q;

   rr_pick #(.N(NPORT), .PW(PTRW)) u_rr_pick (
      .mask    (pick_mask),
      .ptr     (ptr_q),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
      grt     = '0;
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;

      // With no credit the lock state is frozen, including a pending release.
      if (credit_ok) begin
         unique case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  grt   = pick_win;
                  ptr_d = inc_wrap(pick_idx);
                  if (!tail[pick_idx]) begin
                     state_d = ST_LOCKED;
                     owner_d = pick_idx;
                  end
               end
            end
            ST_LOCKED: begin
               if (elig[owner_q]) begin
                  grt = owner_oh;
                  if (tail[owner_q]) state_d = ST_IDLE;
               end else begin
                  // Owner withdrew or rerouted: drop the lock without a grant.
                  state_d = ST_IDLE;
               end
               if (state_d == ST_IDLE) ptr_d = inc_wrap(owner_q);
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (rst_) grt = '0;

      sel_d = grt;
      cnt_d = cnt_q + {{(CNTW-1){1'b0}}, |grt};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its _d value from before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sel      = sel_q;
   assign busy     = (state_q == ST_LOCKED);
   assign flit_cnt = cnt_q;

   a_grt_onehot0: assert property (@(posedge clk) $onehot0(grt));

endmodule
